// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its ALU decoder.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package alu_ctrl_pkg;

    localparam int ALU_W = 4;
    typedef logic [ALU_W-1:0] alu_code_t;

    // ALUControl codes
    localparam alu_code_t ALU_ADD   = 4'h0;
    localparam alu_code_t ALU_SUB   = 4'h1;
    localparam alu_code_t ALU_SLL   = 4'h2;
    localparam alu_code_t ALU_SLT   = 4'h3;
    localparam alu_code_t ALU_SLTU  = 4'h4;
    localparam alu_code_t ALU_XOR   = 4'h5;
    localparam alu_code_t ALU_SRL   = 4'h6;
    localparam alu_code_t ALU_SRA   = 4'h7;
    localparam alu_code_t ALU_OR    = 4'h8;
    localparam alu_code_t ALU_AND   = 4'h9;
    localparam alu_code_t ALU_AUIPC = 4'hA;
    localparam alu_code_t ALU_LUI   = 4'hB;
    localparam alu_code_t ALU_PC4   = 4'hC;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Datapath select encodings
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_A        = 2'b10;
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [2:0] IMM_I         = 3'b000;
    localparam logic [2:0] IMM_S         = 3'b001;
    localparam logic [2:0] IMM_B         = 3'b010;
    localparam logic [2:0] IMM_J         = 3'b011;
    localparam logic [2:0] IMM_U         = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_EXECU, S_ALUWB, S_BRANCH, S_JLINK, S_JTGT, S_TRAP
    } state_t;

    // Operation class handed to the ALU decoder by the FSM
    typedef enum logic [2:0] {
        OPC_ADD, OPC_RTYPE, OPC_ITYPE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_LINK
    } opclass_t;

    // Branch resolution from the compare result. Unknown funct3 is never taken.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        logic t;
        case (f3)
            3'b000:         t = zero;    // beq
            3'b001:         t = ~zero;   // bne
            3'b100, 3'b110: t = ~zero;   // blt/bltu: slt result 1 -> nonzero
            3'b101, 3'b111: t = zero;    // bge/bgeu
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps operation class + funct3/funct7b5 to the 4-bit ALUControl code.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opclass, funct3, funct7b5 in; alu_control out.
module alu_decoder
    import alu_ctrl_pkg::*;
(
    input  opclass_t   opclass,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_code_t  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (opclass)
            OPC_RTYPE, OPC_ITYPE: begin
                case (funct3)
                    // Only the register form may subtract: addi's IR[30] is immediate data.
                    3'b000: alu_control = (opclass == OPC_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        alu_control = ALU_SUB;
                endcase
            end
            OPC_LUI:   alu_control = ALU_LUI;
            OPC_AUIPC: alu_control = ALU_AUIPC;
            OPC_LINK:  alu_control = ALU_PC4;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences memory, ALU and register-file selects/strobes.
// Latency: Moore outputs from state+IR fields; 3-5 cycles per instruction with MemReady=1.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady; write strobes gated by it.
// Ports: clk, rst_n; op/funct3/funct7b5 from IR; Zero from ALU; MemReady/MemReq/MemWrite/AdrSrc
//        to memory; IRWrite/PCWrite/RegWrite, ALUSrcA/B, ResultSrc, ImmSrc, ALUControl to
//        datapath; Retired pulse; Illegal flag.
// Build option: ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state (else NOP).
module multicycle_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic                      funct7b5,
    input  logic                      Zero,
    input  logic                      MemReady,
    output logic                      MemReq,
    output logic                      MemWrite,
    output logic                      AdrSrc,
    output logic                      IRWrite,
    output logic                      PCWrite,
    output logic                      RegWrite,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [1:0]                ResultSrc,
    output logic [2:0]                ImmSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic                      Retired,
    output logic                      Illegal
);

    state_t    state, next_state;
    opclass_t  opclass;
    alu_code_t alu_code;

    logic mem_req, mem_write, ir_write, pc_write, reg_write, retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retired    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        opclass    = OPC_ADD;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LW, OP_SW:      next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL, OP_JALR:   next_state = S_JLINK;
                    OP_LUI, OP_AUIPC:  next_state = S_EXECU;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        next_state = S_TRAP;
`else
                        next_state = S_FETCH;
                        retired    = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_SW) ? IMM_S : IMM_I;
                next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (MemReady) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_write  = 1'b1;
                retired    = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                AdrSrc    = 1'b1;
                retired   = MemReady;
                if (MemReady) next_state = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                opclass    = OPC_RTYPE;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                opclass    = OPC_ITYPE;
                next_state = S_ALUWB;
            end
            S_EXECU: begin
                // The ALU applies the <<12 itself; auipc adds OldPC internally.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                opclass    = (op == OP_LUI) ? OPC_LUI : OPC_AUIPC;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                reg_write  = 1'b1;
                retired    = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ResultSrc  = RES_ALUOUT;
                opclass    = OPC_BRANCH;
                pc_write   = branch_taken(funct3[2:0], Zero);
                retired    = 1'b1;
                next_state = S_FETCH;
            end
            S_JLINK: begin
                // Link first: A was latched earlier, so jalr with rd==rs1 is safe.
                ALUSrcA    = SRCA_OLDPC;
                ResultSrc  = RES_ALURESULT;
                opclass    = OPC_LINK;
                reg_write  = 1'b1;
                next_state = S_JTGT;
            end
            S_JTGT: begin
                ALUSrcA    = (op == OP_JALR) ? SRCA_A : SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_JALR) ? IMM_I : IMM_J;
                ResultSrc  = RES_ALURESULT;
                pc_write   = 1'b1;
                retired    = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .opclass     (opclass),
        .funct3      (funct3[2:0]),
        .funct7b5    (funct7b5),
        .alu_control (alu_code)
    );

    assign ALUControl = alu_code;

    // Reset state is FETCH, which would request memory; mask strobes while rst_n is low.
    assign MemReq   = mem_req   & rst_n;
    assign MemWrite = mem_write & rst_n;
    assign IRWrite  = ir_write  & rst_n;
    assign PCWrite  = pc_write  & rst_n;
    assign RegWrite = reg_write & rst_n;
    assign Retired  = retired   & rst_n;

`ifdef ILLEGAL_TRAP_EN
    assign Illegal = (state == S_TRAP) & rst_n;
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors via a scoreboard.
// Latency: n/a.
// Backpressure: MemReady driven per cycle from the stimulus queue.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       memreq;
        logic       memwrite;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       retired;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic       rdy;
        logic       z;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Retired, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    ctl_t  obs;
    ctl_t  expq[$];
    stim_t stq[$];
    logic [6:0] i_op;
    logic [2:0] i_f3;
    logic       i_f7;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Retired(Retired), .Illegal(Illegal)
    );

    assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, ALUControl, Retired, Illegal};

    // Expected control vectors per FSM step
    function automatic ctl_t x_reset();
        ctl_t c = '0; c.srcb = 2'b10; c.res = 2'b10; return c;
    endfunction
    function automatic ctl_t x_fetch(input logic rdy);
        ctl_t c = '0; c.memreq = 1'b1; c.irwrite = rdy; c.pcwrite = rdy;
        c.srcb = 2'b10; c.res = 2'b10; return c;
    endfunction
    function automatic ctl_t x_decode(input logic nop);
        ctl_t c = '0; c.srca = 2'b01; c.srcb = 2'b01; c.imm = 3'b010; c.retired = nop; return c;
    endfunction
    function automatic ctl_t x_memadr(input logic is_sw);
        ctl_t c = '0; c.srca = 2'b10; c.srcb = 2'b01; c.imm = is_sw ? 3'b001 : 3'b000; return c;
    endfunction
    function automatic ctl_t x_memread();
        ctl_t c = '0; c.memreq = 1'b1; c.adrsrc = 1'b1; return c;
    endfunction
    function automatic ctl_t x_memwb();
        ctl_t c = '0; c.res = 2'b01; c.regwrite = 1'b1; c.retired = 1'b1; return c;
    endfunction
    function automatic ctl_t x_memwrite(input logic rdy);
        ctl_t c = '0; c.memreq = 1'b1; c.memwrite = 1'b1; c.adrsrc = 1'b1; c.retired = rdy; return c;
    endfunction
    function automatic ctl_t x_exec(input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] im, input logic [3:0] a);
        ctl_t c = '0; c.srca = sa; c.srcb = sb; c.imm = im; c.alu = a; return c;
    endfunction
    function automatic ctl_t x_aluwb();
        ctl_t c = '0; c.regwrite = 1'b1; c.retired = 1'b1; return c;
    endfunction
    function automatic ctl_t x_branch(input logic [3:0] a, input logic taken);
        ctl_t c = '0; c.srca = 2'b10; c.alu = a; c.pcwrite = taken; c.retired = 1'b1; return c;
    endfunction
    function automatic ctl_t x_jlink();
        ctl_t c = '0; c.srca = 2'b01; c.alu = 4'hC; c.res = 2'b10; c.regwrite = 1'b1; return c;
    endfunction
    function automatic ctl_t x_jtgt(input logic jr);
        ctl_t c = '0; c.srca = jr ? 2'b10 : 2'b01; c.srcb = 2'b01; c.imm = jr ? 3'b000 : 3'b011;
        c.res = 2'b10; c.pcwrite = 1'b1; c.retired = 1'b1; return c;
    endfunction
    function automatic ctl_t x_trap();
        ctl_t c = '0; c.illegal = 1'b1; return c;
    endfunction

    task automatic push(input logic rdy, input logic z, input ctl_t e);
        stim_t s;
        s.rdy = rdy; s.z = z; s.op = i_op; s.f3 = i_f3; s.f7 = i_f7;
        stq.push_back(s);
        expq.push_back(e);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        i_op = o; i_f3 = f3; i_f7 = f7;
    endtask

    // ALU-class instruction: FETCH, DECODE, EXEC, ALUWB
    task automatic seq_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input ctl_t ex);
        set_instr(o, f3, f7);
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, ex);
        push(1'b1, 1'b0, x_aluwb());
    endtask

    task automatic seq_branch(input logic [2:0] f3, input logic z, input logic [3:0] a,
                              input logic taken);
        set_instr(7'b1100011, f3, 1'b0);
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, z, x_branch(a, taken));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = 7'h0; funct3 = 3'h0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== x_reset()) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, x_reset());
        end
        rst_n = 1'b1; MemReady = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== x_fetch(1'b0)) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", obs, x_fetch(1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        stim_t s; ctl_t e;
        seq_alu(7'b0110011, 3'd0, 1'b0, x_exec(2'b10, 2'b00, 3'b000, 4'h0)); // add
        seq_alu(7'b0110011, 3'd0, 1'b1, x_exec(2'b10, 2'b00, 3'b000, 4'h1)); // sub
        seq_alu(7'b0110011, 3'd5, 1'b1, x_exec(2'b10, 2'b00, 3'b000, 4'h7)); // sra
        seq_alu(7'b0110011, 3'd7, 1'b0, x_exec(2'b10, 2'b00, 3'b000, 4'h9)); // and
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL rtype: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        stim_t s; ctl_t e;
        set_instr(7'b0000011, 3'd2, 1'b0);
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_memadr(1'b0));
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, x_memread());
        push(1'b1, 1'b0, x_memread());
        push(1'b1, 1'b0, x_memwb());
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL load_wait: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        stim_t s; ctl_t e;
        set_instr(7'b0100011, 3'd2, 1'b0);
        push(1'b0, 1'b0, x_fetch(1'b0));
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_memadr(1'b1));
        push(1'b0, 1'b0, x_memwrite(1'b0));
        push(1'b1, 1'b0, x_memwrite(1'b1));
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL store: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branches();
        stim_t s; ctl_t e;
        seq_branch(3'd1, 1'b1, 4'h1, 1'b0); // bne, equal -> not taken
        seq_branch(3'd4, 1'b0, 4'h3, 1'b1); // blt, less -> taken
        seq_branch(3'd7, 1'b1, 4'h4, 1'b1); // bgeu, not less -> taken
        seq_branch(3'd0, 1'b1, 4'h1, 1'b1); // beq, equal -> taken
        seq_branch(3'd5, 1'b0, 4'h3, 1'b0); // bge, less -> not taken
        seq_branch(3'd6, 1'b1, 4'h4, 1'b0); // bltu, not less -> not taken
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL branch: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_itype();
        stim_t s; ctl_t e;
        seq_alu(7'b0010011, 3'd5, 1'b1, x_exec(2'b10, 2'b01, 3'b000, 4'h7)); // srai
        seq_alu(7'b0010011, 3'd0, 1'b1, x_exec(2'b10, 2'b01, 3'b000, 4'h0)); // addi, IR[30]=1
        seq_alu(7'b0010011, 3'd4, 1'b0, x_exec(2'b10, 2'b01, 3'b000, 4'h5)); // xori
        seq_alu(7'b0010011, 3'd5, 1'b0, x_exec(2'b10, 2'b01, 3'b000, 4'h6)); // srli
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL itype: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_upper_jumps();
        stim_t s; ctl_t e;
        seq_alu(7'b0110111, 3'd0, 1'b0, x_exec(2'b01, 2'b01, 3'b100, 4'hB)); // lui
        seq_alu(7'b0010111, 3'd0, 1'b0, x_exec(2'b01, 2'b01, 3'b100, 4'hA)); // auipc
        set_instr(7'b1101111, 3'd0, 1'b0);                                   // jal
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_jlink());
        push(1'b1, 1'b0, x_jtgt(1'b0));
        set_instr(7'b1100111, 3'd0, 1'b0);                                   // jalr
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_jlink());
        push(1'b1, 1'b0, x_jtgt(1'b1));
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL upper_jump: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; ctl_t e;
        set_instr(7'b0100011, 3'd2, 1'b0);                                   // sw
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_memadr(1'b1));
        push(1'b1, 1'b0, x_memwrite(1'b1));
        seq_branch(3'd0, 1'b1, 4'h1, 1'b1);                                  // beq taken
        seq_alu(7'b0010011, 3'd6, 1'b0, x_exec(2'b10, 2'b01, 3'b000, 4'h8)); // ori
        set_instr(7'b0000011, 3'd2, 1'b0);                                   // lw, no wait
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_memadr(1'b0));
        push(1'b1, 1'b0, x_memread());
        push(1'b1, 1'b0, x_memwb());
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL back_to_back: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t s; ctl_t e;
        set_instr(7'h7F, 3'd0, 1'b0);
        push(1'b1, 1'b0, x_fetch(1'b1));
`ifdef ILLEGAL_TRAP_EN
        push(1'b1, 1'b0, x_decode(1'b0));
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, x_trap());
`else
        push(1'b1, 1'b0, x_decode(1'b1));
        push(1'b0, 1'b0, x_fetch(1'b0));
`endif
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL illegal: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
`ifdef ILLEGAL_TRAP_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; MemReady = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== x_fetch(1'b0)) begin
            n_fail++; $display("FAIL trap_exit: got %h expected %h", obs, x_fetch(1'b0));
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_reset_mid();
        stim_t s; ctl_t e;
        set_instr(7'b0000011, 3'd2, 1'b0);
        push(1'b1, 1'b0, x_fetch(1'b1));
        push(1'b1, 1'b0, x_decode(1'b0));
        push(1'b1, 1'b0, x_memadr(1'b0));
        push(1'b0, 1'b0, x_memread());
        while (expq.size() > 0) begin
            s = stq.pop_front();
            MemReady = s.rdy; Zero = s.z; op = s.op; funct3 = s.f3; funct7b5 = s.f7;
            @(negedge clk);
            e = expq.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_mid_pre: got %h expected %h", obs, e); end
            @(posedge clk); #1;
        end
        // Still in MEMREAD here; reset must kill the strobes without waiting for a clock.
        MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== x_reset()) begin
            n_fail++; $display("FAIL reset_mid_async: got %h expected %h", obs, x_reset());
        end
        @(posedge clk); #1;
        rst_n = 1'b1; MemReady = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== x_fetch(1'b0)) begin
            n_fail++; $display("FAIL reset_mid_release: got %h expected %h", obs, x_fetch(1'b0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branches();
        test_itype();
        test_upper_jumps();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
